// File: rtl/pipe_pkg.sv
// Shared field widths, stage bundle layouts and skid-slot state encodings
// for the in-order core pipeline registers.
package pipe_pkg;

  localparam int BR_TYPE_W  = 2;
  localparam int EXE_CMD_W  = 4;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [BR_TYPE_W-1:0] br_type;
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic                 wb_en;
  } id_ctrl_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [XLEN-1:0]       reg2;
    logic [XLEN-1:0]       val2;
    logic [XLEN-1:0]       val1;
    logic [XLEN-1:0]       pc;
  } id_data_t;

  localparam int ID_CTRL_W = $bits(id_ctrl_t);
  localparam int ID_DATA_W = $bits(id_data_t);

  // All-zero control decodes as a NOP: no writeback, no memory access.
  localparam id_ctrl_t CTRL_NOP = '0;

  // Slot state is {main_v, skid_v}; a skid beat without a main beat is illegal.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;
  localparam logic [1:0] ST_BAD   = 2'b01;

endpackage

// File: rtl/pipe_skid_slot.sv
// One elastic pipeline stage: a main entry plus a skid entry, so the
// upstream ready can be a flop without losing the beat in flight.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = ID_CTRL_W,
  parameter int DATA_W   = ID_DATA_W,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        valid_nxt
);

  logic              main_v, skid_v, main_v_n, skid_v_n;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_n, skid_ctrl_n;
  logic [DATA_W-1:0] main_data, skid_data, main_data_n, skid_data_n;
  logic [1:0]        state;
  logic              accept, drain;

  assign state     = {main_v, skid_v};
  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign accept    = in_valid && !skid_v;
  assign drain     = main_v && out_ready;
  assign valid_nxt = {main_v_n, skid_v_n};

  always_comb begin
    main_v_n    = main_v;
    skid_v_n    = skid_v;
    main_ctrl_n = main_ctrl;
    skid_ctrl_n = skid_ctrl;
    main_data_n = main_data;
    skid_data_n = skid_data;
    if (flush) begin
      main_v_n    = 1'b0;
      skid_v_n    = 1'b0;
      main_ctrl_n = '0;
      skid_ctrl_n = '0;
      if (CLR_DATA) begin
        main_data_n = '0;
        skid_data_n = '0;
      end
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          main_v_n    = 1'b1;
          main_ctrl_n = in_ctrl;
          main_data_n = in_data;
        end
        ST_ONE: if (accept && drain) begin
          main_ctrl_n = in_ctrl;
          main_data_n = in_data;
        end else if (accept) begin
          skid_v_n    = 1'b1;
          skid_ctrl_n = in_ctrl;
          skid_data_n = in_data;
        end else if (drain) begin
          main_v_n = 1'b0;
        end
        // Skid always refills main, so the older beat leaves first.
        ST_FULL: if (drain) begin
          skid_v_n    = 1'b0;
          main_ctrl_n = skid_ctrl;
          main_data_n = skid_data;
        end
        default: begin
          main_v_n = 1'b0;
          skid_v_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      main_v    <= main_v_n;
      skid_v    <= skid_v_n;
      main_ctrl <= main_ctrl_n;
      skid_ctrl <= skid_ctrl_n;
    end
  end

  // Payload only carries a reset when it is also cleared on flush.
  if (CLR_DATA) begin : g_clr_data
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_data <= '0;
        skid_data <= '0;
      end else begin
        main_data <= main_data_n;
        skid_data <= skid_data_n;
      end
    end
  end else begin : g_keep_data
    always_ff @(posedge clk) begin
      main_data <= main_data_n;
      skid_data <= skid_data_n;
    end
  end

  a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst) state != ST_BAD);

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: DEPTH chained skid slots with flush, NOP
// masking of bubbles and a registered occupancy count.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int  CTRL_W   = ID_CTRL_W,
  parameter int  DATA_W   = ID_DATA_W,
  parameter int  DEPTH    = 1,
  parameter bit  CLR_DATA = 1'b1,
  localparam int OCC_W    = $clog2(2*DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  logic [DEPTH:0]             ch_valid;
  logic [DEPTH:0]             ch_ready;
  logic [DEPTH:0][CTRL_W-1:0] ch_ctrl;
  logic [DEPTH:0][DATA_W-1:0] ch_data;
  logic [DEPTH-1:0][1:0]      valid_nxt;
  logic [OCC_W-1:0]           occ_nxt;

  assign ch_valid[0]     = in_valid;
  assign ch_ctrl[0]      = in_ctrl;
  assign ch_data[0]      = in_data;
  assign in_ready        = ch_ready[0];
  assign ch_ready[DEPTH] = out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_skid_slot #(
      .CTRL_W  (CTRL_W),
      .DATA_W  (DATA_W),
      .CLR_DATA(CLR_DATA)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (ch_valid[g]),
      .in_ready (ch_ready[g]),
      .in_ctrl  (ch_ctrl[g]),
      .in_data  (ch_data[g]),
      .out_valid(ch_valid[g+1]),
      .out_ready(ch_ready[g+1]),
      .out_ctrl (ch_ctrl[g+1]),
      .out_data (ch_data[g+1]),
      .valid_nxt(valid_nxt[g])
    );
  end

  // Bubbles decode as NOP so consumers that ignore valid stay safe.
  assign out_valid = ch_valid[DEPTH];
  assign out_ctrl  = ch_valid[DEPTH] ? ch_ctrl[DEPTH] : CTRL_W'(CTRL_NOP);
  assign out_data  = ch_data[DEPTH];

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt = occ_nxt + OCC_W'(valid_nxt[i][1]) + OCC_W'(valid_nxt[i][0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occupancy <= '0;
    else     occupancy <= occ_nxt;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a DEPTH=2 and a DEPTH=1 instance
// share clock and reset; expected beats queue on accept and pop on delivery.
module tb_pipe_stage_reg;

  localparam int CW = 9;
  localparam int DW = 133;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush2, iv2, ir2, ov2, or2;
  logic [CW-1:0] ic2, oc2;
  logic [DW-1:0] id2, od2;
  logic [2:0]    occ2;
  logic          flush1, iv1, ir1, ov1, or1;
  logic [CW-1:0] ic1, oc1;
  logic [DW-1:0] id1, od1;
  logic [1:0]    occ1;

  int    checks = 0;
  int    failures = 0;
  beat_t q2[$];
  beat_t q1[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2), .CLR_DATA(1'b1)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush2),
    .in_valid(iv2), .in_ready(ir2), .in_ctrl(ic2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_ctrl(oc2), .out_data(od2),
    .occupancy(occ2)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(1), .CLR_DATA(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(iv1), .in_ready(ir1), .in_ctrl(ic1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_ctrl(oc1), .out_data(od1),
    .occupancy(occ1)
  );

  function automatic beat_t mk(input logic [CW-1:0] c, input logic [DW-1:0] d);
    beat_t b;
    b.c = c;
    b.d = d;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.c = CW'($urandom());
    b.d = DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    return b;
  endfunction

  // One cycle on the DEPTH=2 instance: drive at negedge, log handshakes, advance.
  task automatic step2(input logic v, input beat_t b, input logic ordy, input logic fl,
                       output logic acc, output logic pop, output beat_t exp_b, output beat_t got_b);
    iv2 = v; ic2 = b.c; id2 = b.d; or2 = ordy; flush2 = fl;
    #1;
    acc = v && ir2;
    pop = ov2 && ordy;
    got_b.c = oc2;
    got_b.d = od2;
    exp_b = 'x;
    if (pop && q2.size() > 0) exp_b = q2.pop_front();
    if (fl) q2.delete();
    else if (acc) q2.push_back(b);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step1(input logic v, input beat_t b, input logic ordy, input logic fl,
                       output logic acc, output logic pop, output beat_t exp_b, output beat_t got_b);
    iv1 = v; ic1 = b.c; id1 = b.d; or1 = ordy; flush1 = fl;
    #1;
    acc = v && ir1;
    pop = ov1 && ordy;
    got_b.c = oc1;
    got_b.d = od1;
    exp_b = 'x;
    if (pop && q1.size() > 0) exp_b = q1.pop_front();
    if (fl) q1.delete();
    else if (acc) q1.push_back(b);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL reset_out_valid_d2 got=%b exp=0", ov2); end
    checks++; if (ir2 !== 1'b1) begin failures++; $display("FAIL reset_in_ready_d2 got=%b exp=1", ir2); end
    checks++; if (occ2 !== 3'd0) begin failures++; $display("FAIL reset_occ_d2 got=%0d exp=0", occ2); end
    checks++; if (oc2 !== '0) begin failures++; $display("FAIL reset_out_ctrl_d2 got=%h exp=0", oc2); end
    checks++; if (od2 !== '0) begin failures++; $display("FAIL reset_out_data_d2 got=%h exp=0", od2); end
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL reset_out_valid_d1 got=%b exp=0", ov1); end
    checks++; if (ir1 !== 1'b1) begin failures++; $display("FAIL reset_in_ready_d1 got=%b exp=1", ir1); end
    checks++; if (occ1 !== 2'd0) begin failures++; $display("FAIL reset_occ_d1 got=%0d exp=0", occ1); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    beat_t bs[3];
    beat_t none, e, g;
    logic  a, p;
    int    first_vis = -1, first_pop = -1, last_pop = -1, npop = 0;
    none  = '0;
    bs[0] = mk(9'h1FF, DW'(128'hD0D0_0000_1111_2222_3333_4444_5555_6666));
    bs[1] = mk(9'h0A5, DW'(128'hD1D1_7777_8888_9999_AAAA_BBBB_CCCC_DDDD));
    bs[2] = mk(9'h155, DW'(128'hD2D2_EEEE_FFFF_0123_4567_89AB_CDEF_0F0F));
    for (int k = 0; k < 8; k++) begin
      step2(k < 3, bs[k % 3], 1'b1, 1'b0, a, p, e, g);
      if (p) begin
        npop++;
        if (first_pop < 0) first_pop = k;
        last_pop = k;
        checks++; if (g !== e) begin failures++; $display("FAIL stream_beat got=%h exp=%h", g, e); end
      end
      checks++; if (int'(occ2) !== q2.size()) begin failures++; $display("FAIL stream_occ got=%0d exp=%0d", occ2, q2.size()); end
      if (ov2 && first_vis < 0) first_vis = k;
    end
    checks++; if (first_vis !== 1) begin failures++; $display("FAIL stream_latency got=%0d exp=1", first_vis); end
    checks++; if (first_pop !== 2) begin failures++; $display("FAIL stream_first_pop got=%0d exp=2", first_pop); end
    checks++; if (last_pop !== 4) begin failures++; $display("FAIL stream_back_to_back got=%0d exp=4", last_pop); end
    checks++; if (npop !== 3) begin failures++; $display("FAIL stream_count got=%0d exp=3", npop); end
  endtask

  task automatic test_backpressure();
    beat_t bs[3];
    beat_t none, e, g;
    logic  a, p;
    int    acc_k = -1;
    none = '0;
    for (int k = 0; k < 3; k++) bs[k] = rand_beat();
    for (int k = 0; k < 3; k++) begin
      step1(1'b1, bs[k], 1'b0, 1'b0, a, p, e, g);
      checks++; if (ir1 !== (q1.size() < 2)) begin failures++; $display("FAIL bp_fill_ready got=%b exp=%b", ir1, q1.size() < 2); end
    end
    checks++; if (ir1 !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", ir1); end
    checks++; if (occ1 !== 2'd2) begin failures++; $display("FAIL bp_full_occ got=%0d exp=2", occ1); end
    for (int k = 0; k < 6 && acc_k < 0; k++) begin
      step1(1'b1, bs[2], 1'b1, 1'b0, a, p, e, g);
      if (p) begin
        checks++; if (g !== e) begin failures++; $display("FAIL bp_release_beat got=%h exp=%h", g, e); end
      end
      if (a) acc_k = k;
    end
    checks++; if (acc_k !== 1) begin failures++; $display("FAIL bp_third_accept got=%0d exp=1", acc_k); end
    for (int k = 0; k < 4; k++) begin
      step1(1'b0, none, 1'b1, 1'b0, a, p, e, g);
      if (p) begin
        checks++; if (g !== e) begin failures++; $display("FAIL bp_drain_beat got=%h exp=%h", g, e); end
      end
      checks++; if (int'(occ1) !== q1.size()) begin failures++; $display("FAIL bp_drain_occ got=%0d exp=%0d", occ1, q1.size()); end
    end
  endtask

  task automatic test_flush();
    beat_t none, e, g;
    logic  a, p;
    none = '0;
    for (int k = 0; k < 3; k++) step2(1'b1, rand_beat(), 1'b0, 1'b0, a, p, e, g);
    checks++; if (occ2 !== 3'd3) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=3", occ2); end
    step2(1'b1, rand_beat(), 1'b0, 1'b1, a, p, e, g);
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", ov2); end
    checks++; if (oc2 !== '0) begin failures++; $display("FAIL flush_out_ctrl got=%h exp=0", oc2); end
    checks++; if (occ2 !== 3'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occ2); end
    checks++; if (od2 !== '0) begin failures++; $display("FAIL flush_out_data got=%h exp=0", od2); end
    for (int k = 0; k < 4; k++) begin
      step2(1'b0, none, 1'b1, 1'b0, a, p, e, g);
      if (p) begin
        checks++; if (g !== e) begin failures++; $display("FAIL flush_ghost_beat got=%h exp=%h", g, e); end
      end
    end
  endtask

  task automatic test_flush_drain();
    beat_t none, e, g;
    logic  a, p;
    int    extra = 0;
    none = '0;
    step2(1'b1, rand_beat(), 1'b1, 1'b0, a, p, e, g);
    step2(1'b1, rand_beat(), 1'b1, 1'b0, a, p, e, g);
    checks++; if (ov2 !== 1'b1) begin failures++; $display("FAIL fd_pre_valid got=%b exp=1", ov2); end
    step2(1'b1, rand_beat(), 1'b1, 1'b1, a, p, e, g);
    checks++; if (p !== 1'b1 || g !== e) begin failures++; $display("FAIL fd_consumed got=%h exp=%h", g, e); end
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL fd_post_valid got=%b exp=0", ov2); end
    for (int k = 0; k < 4; k++) begin
      step2(1'b0, none, 1'b1, 1'b0, a, p, e, g);
      if (p) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL fd_duplicate got=%0d exp=0", extra); end
  endtask

  task automatic test_async_reset();
    beat_t e, g;
    logic  a, p;
    step1(1'b1, rand_beat(), 1'b0, 1'b0, a, p, e, g);
    step1(1'b1, rand_beat(), 1'b0, 1'b0, a, p, e, g);
    checks++; if (ir1 !== 1'b0) begin failures++; $display("FAIL ar_pre_full got=%b exp=0", ir1); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL ar_out_valid got=%b exp=0", ov1); end
    checks++; if (ir1 !== 1'b1) begin failures++; $display("FAIL ar_in_ready got=%b exp=1", ir1); end
    checks++; if (occ1 !== 2'd0) begin failures++; $display("FAIL ar_occ got=%0d exp=0", occ1); end
    checks++; if (oc1 !== '0) begin failures++; $display("FAIL ar_out_ctrl got=%h exp=0", oc1); end
    q1.delete();
    q2.delete();
    iv1 = 1'b0; or1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_soak();
    beat_t none, e, g;
    logic  a, p, v, ordy, fl;
    none = '0;
    for (int k = 0; k < 10000; k++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 1) != 0);
      fl   = ($urandom_range(0, 99) == 0);
      step2(v, rand_beat(), ordy, fl, a, p, e, g);
      if (p) begin
        checks++; if (g !== e) begin failures++; $display("FAIL soak_beat cycle=%0d got=%h exp=%h", k, g, e); end
      end
      checks++; if (int'(occ2) !== q2.size()) begin failures++; $display("FAIL soak_occ cycle=%0d got=%0d exp=%0d", k, occ2, q2.size()); end
      if (!ov2) begin
        checks++; if (oc2 !== '0) begin failures++; $display("FAIL soak_bubble cycle=%0d got=%h exp=0", k, oc2); end
      end
    end
    for (int k = 0; k < 12 && q2.size() > 0; k++) begin
      step2(1'b0, none, 1'b1, 1'b0, a, p, e, g);
      if (p) begin
        checks++; if (g !== e) begin failures++; $display("FAIL soak_drain_beat got=%h exp=%h", g, e); end
      end
    end
    checks++; if (q2.size() !== 0) begin failures++; $display("FAIL soak_drain_timeout got=%0d exp=0", q2.size()); end
    checks++; if (occ2 !== 3'd0) begin failures++; $display("FAIL soak_final_occ got=%0d exp=0", occ2); end
  endtask

  initial begin
    rst = 1'b1;
    flush2 = 1'b0; iv2 = 1'b0; or2 = 1'b0; ic2 = '0; id2 = '0;
    flush1 = 1'b0; iv1 = 1'b0; or1 = 1'b0; ic1 = '0; id1 = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_drain();
    test_async_reset();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
